// File: rtl/isp_strip_parser_pkg.sv
// Shared constants, types and helpers for the ISP strip parser.
// Vertex field layout is derived from the ISP flag bits decoded here.
package pvr_isp_pkg;

    localparam int ISP_DCMP_HI  = 31;
    localparam int ISP_DCMP_LO  = 29;
    localparam int ISP_CULL_HI  = 28;
    localparam int ISP_CULL_LO  = 27;
    localparam int ISP_TEX_BIT  = 25;
    localparam int ISP_OFS_BIT  = 24;
    localparam int ISP_GOUR_BIT = 23;
    localparam int ISP_UV16_BIT = 22;

    localparam int NUM_FIELDS = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_VTX,
        ST_EMIT
    } isp_state_e;

    // Enum values double as indices into the vertex field storage.
    typedef enum logic [2:0] {
        FS_X,
        FS_Y,
        FS_Z,
        FS_U,
        FS_V,
        FS_COL,
        FS_OFS,
        FS_SKIP
    } isp_field_e;

    function automatic logic [3:0] isp_uv_words(input logic texture, input logic uv16);
        return texture ? (uv16 ? 4'd1 : 4'd2) : 4'd0;
    endfunction

    function automatic logic [3:0] isp_vtx_words(input logic texture, input logic uv16,
                                                 input logic offset, input logic two_vol);
        logic [3:0] vol;
        vol = isp_uv_words(texture, uv16) + 4'd1 + {3'b000, offset};
        return 4'd3 + vol + (two_vol ? vol : 4'd0);
    endfunction

endpackage

// File: rtl/isp_strip_parser_if.sv
// Command, VRAM read and triangle handshake bundle for the strip parser.
// The slave modport is the parser side; master is the requester/memory side.
interface isp_strip_parser_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
);
    logic                start;
    logic [ADDR_W-1:0]   poly_addr;
    logic [CNT_W-1:0]    strip_len;
    logic                two_volume;
    logic                vram_rd;
    logic [ADDR_W-1:0]   vram_addr;
    logic [DATA_W-1:0]   vram_din;
    logic                vram_valid;
    logic                busy;
    logic [DATA_W-1:0]   isp_inst;
    logic [DATA_W-1:0]   tsp_inst;
    logic [DATA_W-1:0]   tex_cont;
    logic [3*DATA_W-1:0] tri_x;
    logic [3*DATA_W-1:0] tri_y;
    logic [3*DATA_W-1:0] tri_z;
    logic [3*DATA_W-1:0] tri_u;
    logic [3*DATA_W-1:0] tri_v;
    logic [3*DATA_W-1:0] tri_col;
    logic [3*DATA_W-1:0] tri_ofs;
    logic                tri_odd;
    logic                tri_valid;
    logic                tri_ready;
    logic                poly_done;

    modport slave (
        input  start, poly_addr, strip_len, two_volume, vram_din, vram_valid, tri_ready,
        output vram_rd, vram_addr, busy, isp_inst, tsp_inst, tex_cont,
               tri_x, tri_y, tri_z, tri_u, tri_v, tri_col, tri_ofs,
               tri_odd, tri_valid, poly_done
    );

    modport master (
        output start, poly_addr, strip_len, two_volume, vram_din, vram_valid, tri_ready,
        input  vram_rd, vram_addr, busy, isp_inst, tsp_inst, tex_cont,
               tri_x, tri_y, tri_z, tri_u, tri_v, tri_col, tri_ofs,
               tri_odd, tri_valid, poly_done
    );
endinterface

// File: rtl/isp_strip_parser_vtx_layout.sv
// Maps a word index within one vertex to the field it carries.
// Everything past the first volume (second UV group, COL1, OFS1) maps to SKIP.
module isp_vtx_layout
    import pvr_isp_pkg::*;
(
    input  logic [3:0] i_word_idx,
    input  logic       i_texture,
    input  logic       i_uv16,
    input  logic       i_offset,
    output isp_field_e o_sel
);
    logic [3:0] w_uvw;
    logic [3:0] w_j;
    logic [3:0] w_k;

    always_comb begin
        w_uvw = isp_uv_words(i_texture, i_uv16);
        w_j   = i_word_idx - 4'd3;
        w_k   = w_j - w_uvw;
        o_sel = FS_SKIP;
        if (i_word_idx < 4'd3)
            o_sel = isp_field_e'(i_word_idx[2:0]);
        else if (w_j < w_uvw)
            o_sel = (w_j == 4'd0) ? FS_U : FS_V;
        else if (w_k == 4'd0)
            o_sel = FS_COL;
        else if ((w_k == 4'd1) && i_offset)
            o_sel = FS_OFS;
    end
endmodule

// File: rtl/isp_strip_parser.sv
// Walks a polygon parameter block in VRAM, decodes the header and strip
// vertices, and presents each A/B/C strip triangle over valid/ready.
module isp_strip_parser
    import pvr_isp_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int MAX_STRIP = 8,
    parameter int CNT_W     = 4
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    isp_strip_parser_if.slave bus
);
    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(3);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_STRIP);

    isp_state_e        r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_len, r_vtx_cnt;
    logic [2:0]        r_hdr_idx;
    logic [3:0]        r_word_idx, r_words;
    logic              r_two_vol, r_odd, r_done;
    logic [DATA_W-1:0] r_isp, r_tsp, r_tex;
    // [field][slot]: slot 0 = A, 1 = B, 2 = C (C is the vertex being fetched)
    logic [NUM_FIELDS-1:0][2:0][DATA_W-1:0] r_vf;
    logic [NUM_FIELDS-1:0][DATA_W-1:0]      w_c;

    logic              w_rd, w_beat, w_hdr_last, w_vtx_last, w_more;
    logic [CNT_W-1:0]  w_cnt_inc, w_len;
    isp_field_e        w_sel;

    isp_vtx_layout u_layout (
        .i_word_idx (r_word_idx),
        .i_texture  (r_isp[ISP_TEX_BIT]),
        .i_uv16     (r_isp[ISP_UV16_BIT]),
        .i_offset   (r_isp[ISP_OFS_BIT]),
        .o_sel      (w_sel)
    );

    assign w_rd       = (r_state == ST_HDR) || (r_state == ST_VTX);
    assign w_beat     = w_rd && bus.vram_valid;
    assign w_hdr_last = r_hdr_idx == (r_two_vol ? 3'd4 : 3'd2);
    assign w_vtx_last = r_word_idx == (r_words - 4'd1);
    assign w_cnt_inc  = r_vtx_cnt + CNT_W'(1);
    assign w_more     = r_vtx_cnt < r_len;

    always_comb begin
        w_len = bus.strip_len;
        if (bus.strip_len < MIN_LEN)
            w_len = MIN_LEN;
        else if (bus.strip_len > MAX_LEN)
            w_len = MAX_LEN;
    end

    // Slot C with the current beat merged in, so a shift can use the fresh word.
    always_comb begin
        for (int f = 0; f < NUM_FIELDS; f++)
            w_c[f] = r_vf[f][2];
        if (w_sel != FS_SKIP)
            w_c[w_sel] = bus.vram_din;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next = ST_HDR;
            ST_HDR:  if (w_beat && w_hdr_last) w_next = ST_VTX;
            ST_VTX:  if (w_beat && w_vtx_last && (w_cnt_inc >= MIN_LEN)) w_next = ST_EMIT;
            ST_EMIT: if (bus.tri_ready) w_next = w_more ? ST_VTX : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_vtx_cnt  <= '0;
            r_hdr_idx  <= '0;
            r_word_idx <= '0;
            r_words    <= '0;
            r_two_vol  <= 1'b0;
            r_odd      <= 1'b0;
            r_done     <= 1'b0;
            r_isp      <= '0;
            r_tsp      <= '0;
            r_tex      <= '0;
            r_vf       <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_beat)
                r_addr <= r_addr + ADDR_W'(4);
            case (r_state)
                ST_IDLE: if (bus.start) begin
                    r_addr     <= bus.poly_addr;
                    r_len      <= w_len;
                    r_two_vol  <= bus.two_volume;
                    r_vtx_cnt  <= '0;
                    r_hdr_idx  <= '0;
                    r_word_idx <= '0;
                    r_odd      <= 1'b0;
                    r_isp      <= '0;
                    r_tsp      <= '0;
                    r_tex      <= '0;
                    r_vf       <= '0;
                end
                ST_HDR: if (w_beat) begin
                    r_hdr_idx <= r_hdr_idx + 3'd1;
                    case (r_hdr_idx)
                        3'd0: begin
                            r_isp   <= bus.vram_din;
                            r_words <= isp_vtx_words(bus.vram_din[ISP_TEX_BIT],
                                                     bus.vram_din[ISP_UV16_BIT],
                                                     bus.vram_din[ISP_OFS_BIT], r_two_vol);
                        end
                        3'd1:    r_tsp <= bus.vram_din;
                        3'd2:    r_tex <= bus.vram_din;
                        default: ;
                    endcase
                end
                ST_VTX: if (w_beat) begin
                    for (int f = 0; f < NUM_FIELDS; f++)
                        r_vf[f][2] <= w_c[f];
                    if (w_vtx_last) begin
                        r_word_idx <= '0;
                        r_vtx_cnt  <= w_cnt_inc;
                        if (w_cnt_inc < MIN_LEN) begin
                            for (int f = 0; f < NUM_FIELDS; f++) begin
                                r_vf[f][0] <= r_vf[f][1];
                                r_vf[f][1] <= w_c[f];
                            end
                        end
                    end else begin
                        r_word_idx <= r_word_idx + 4'd1;
                    end
                end
                ST_EMIT: if (bus.tri_ready) begin
                    r_odd <= ~r_odd;
                    if (w_more) begin
                        for (int f = 0; f < NUM_FIELDS; f++) begin
                            r_vf[f][0] <= r_vf[f][1];
                            r_vf[f][1] <= r_vf[f][2];
                        end
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.vram_rd   = w_rd;
    assign bus.vram_addr = r_addr;
    assign bus.busy      = r_state != ST_IDLE;
    assign bus.isp_inst  = r_isp;
    assign bus.tsp_inst  = r_tsp;
    assign bus.tex_cont  = r_tex;
    assign bus.tri_x     = r_vf[FS_X];
    assign bus.tri_y     = r_vf[FS_Y];
    assign bus.tri_z     = r_vf[FS_Z];
    assign bus.tri_u     = r_vf[FS_U];
    assign bus.tri_v     = r_vf[FS_V];
    assign bus.tri_col   = r_vf[FS_COL];
    assign bus.tri_ofs   = r_vf[FS_OFS];
    assign bus.tri_odd   = r_odd;
    assign bus.tri_valid = r_state == ST_EMIT;
    assign bus.poly_done = r_done;
endmodule

// File: tb/tb_isp_strip_parser.sv
// Scoreboard bench for isp_strip_parser: a VRAM model feeds the parser and
// expected triangles, built from the same memory image, are checked on output.
module tb_isp_strip_parser;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int CW = 4;

    typedef struct packed {
        logic [6:0][3*DW-1:0] f;
        logic                 odd;
    } tri_t;

    logic clk, rst_n;
    isp_strip_parser_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();
    isp_strip_parser #(.ADDR_W(AW), .DATA_W(DW), .MAX_STRIP(8), .CNT_W(CW)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    logic [DW-1:0] mem [0:255];
    tri_t  q[$];
    int    n_cmp, n_bad, n_acc, stall_cnt;
    bit    tgl_mode, stall_mode;
    string cur_test;
    string fname [7] = '{"x", "y", "z", "u", "v", "col", "ofs"};

    assign bus.vram_din = mem[bus.vram_addr[9:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL [%s] %s: got %h expected %h", cur_test, tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] make_isp(input logic [AW-1:0] base, input bit tex,
                                               input bit uv16, input bit ofs);
        logic [DW-1:0] w;
        w = 32'hA5C3_9E17 ^ {8'h00, base};
        w[25] = tex;
        w[24] = ofs;
        w[22] = uv16;
        return w;
    endfunction

    // Independent model: explicit per-field word offsets within each vertex.
    task automatic push_expected(input logic [AW-1:0] base, input int len, input bit tv,
                                 input bit tex, input bit uv16, input bit ofs,
                                 output int ntri, output int fin);
        int b, hdr, uvw, words, n, s;
        logic [DW-1:0] vf [8][7];
        tri_t e;
        b     = int'(base) / 4;
        hdr   = tv ? 5 : 3;
        uvw   = tex ? (uv16 ? 1 : 2) : 0;
        words = 3 + (uvw + 1 + int'(ofs)) * (tv ? 2 : 1);
        n     = (len < 3) ? 3 : ((len > 8) ? 8 : len);
        for (int v = 0; v < n; v++) begin
            s = b + hdr + v * words;
            vf[v][0] = mem[s];
            vf[v][1] = mem[s + 1];
            vf[v][2] = mem[s + 2];
            vf[v][3] = tex ? mem[s + 3] : '0;
            vf[v][4] = (tex && !uv16) ? mem[s + 4] : '0;
            vf[v][5] = mem[s + 3 + uvw];
            vf[v][6] = ofs ? mem[s + 4 + uvw] : '0;
        end
        for (int t = 0; t < n - 2; t++) begin
            for (int k = 0; k < 7; k++)
                e.f[k] = {vf[t + 2][k], vf[t + 1][k], vf[t][k]};
            e.odd = (t % 2) == 1;
            q.push_back(e);
        end
        ntri = n - 2;
        fin  = int'(base) + 4 * (hdr + n * words);
    endtask

    // Output monitor: every valid cycle must show the scoreboard head.
    initial begin
        logic [6:0][95:0] obs;
        tri_t e;
        forever begin
            @(negedge clk);
            if (bus.tri_valid) begin
                chk("vram_rd_in_emit", 96'(bus.vram_rd), 96'(0));
                if (q.size() == 0) begin
                    chk("unexpected_tri", 96'(bus.tri_valid), 96'(0));
                end else begin
                    e   = q[0];
                    obs = {bus.tri_ofs, bus.tri_col, bus.tri_v, bus.tri_u,
                           bus.tri_z, bus.tri_y, bus.tri_x};
                    for (int k = 0; k < 7; k++)
                        chk({"tri_", fname[k]}, obs[k], e.f[k]);
                    chk("tri_odd", 96'(bus.tri_odd), 96'(e.odd));
                    if (bus.tri_ready) begin
                        void'(q.pop_front());
                        n_acc++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.vram_valid = tgl_mode ? ~bus.vram_valid : 1'b1;
        end
    end

    // Ready holds low for the first 5 cycles of every EMIT in stall mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!stall_mode) bus.tri_ready = 1'b1;
            else if (!bus.tri_valid) begin
                bus.tri_ready = 1'b0;
                stall_cnt = 0;
            end else if (stall_cnt < 5) begin
                bus.tri_ready = 1'b0;
                stall_cnt++;
            end else bus.tri_ready = 1'b1;
        end
    end

    task automatic kick(input logic [AW-1:0] base, input int len, input bit tv);
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.poly_addr  = base;
        bus.strip_len  = CW'(len);
        bus.two_volume = tv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_parse(input string name, input logic [AW-1:0] base, input int len,
                             input bit tv, input bit tex, input bit uv16, input bit ofs,
                             input bit tgl, input bit stall);
        int  ntri, fin, b;
        bit  done;
        cur_test   = name;
        b          = int'(base) / 4;
        mem[b]     = make_isp(base, tex, uv16, ofs);
        push_expected(base, len, tv, tex, uv16, ofs, ntri, fin);
        n_acc      = 0;
        tgl_mode   = tgl;
        stall_mode = stall;
        kick(base, len, tv);
        chk("busy_after_start", 96'(bus.busy), 96'(1));
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (bus.poly_done) begin
                done = 1;
                chk("busy_at_done", 96'(bus.busy), 96'(0));
            end
        end
        chk("done_seen", 96'(done), 96'(1));
        chk("tri_count", 96'(n_acc), 96'(ntri));
        chk("queue_empty", 96'(q.size()), 96'(0));
        chk("final_addr", 96'(bus.vram_addr), 96'(fin));
        chk("isp_inst", 96'(bus.isp_inst), 96'(mem[b]));
        chk("tsp_inst", 96'(bus.tsp_inst), 96'(mem[b + 1]));
        chk("tex_cont", 96'(bus.tex_cont), 96'(mem[b + 2]));
        q.delete();
        @(negedge clk);
        chk("busy_after_done", 96'(bus.busy), 96'(0));
        chk("done_one_cycle", 96'(bus.poly_done), 96'(0));
    endtask

    task automatic chk_zero_outputs();
        chk("rst_vram_rd", 96'(bus.vram_rd), 96'(0));
        chk("rst_vram_addr", 96'(bus.vram_addr), 96'(0));
        chk("rst_busy", 96'(bus.busy), 96'(0));
        chk("rst_tri_valid", 96'(bus.tri_valid), 96'(0));
        chk("rst_tri_x", bus.tri_x, 96'(0));
        chk("rst_tri_u", bus.tri_u, 96'(0));
        chk("rst_tri_odd", 96'(bus.tri_odd), 96'(0));
        chk("rst_isp_inst", 96'(bus.isp_inst), 96'(0));
        chk("rst_poly_done", 96'(bus.poly_done), 96'(0));
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_acc = 0; stall_cnt = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.poly_addr = '0; bus.strip_len = '0; bus.two_volume = 1'b0;
        bus.vram_valid = 1'b0; bus.tri_ready = 1'b0;
        tgl_mode = 1'b0; stall_mode = 1'b0;
        cur_test = "reset";
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #2;
        chk_zero_outputs();
        rst_n = 1'b1;

        run_parse("untex_len3",         24'h000,  3, 0, 0, 0, 0, 0, 0);
        run_parse("tex_uv16_ofs_len5",  24'h080,  5, 0, 1, 1, 1, 0, 0);
        run_parse("two_vol_len4",       24'h140,  4, 1, 1, 0, 1, 0, 0);
        run_parse("stall_tex_uv16",     24'h080,  5, 0, 1, 1, 1, 1, 1);
        run_parse("len1",               24'h000,  1, 0, 0, 0, 0, 0, 0);
        run_parse("len15_clamp",        24'h200, 15, 0, 0, 0, 1, 0, 0);

        cur_test   = "reset_mid_vtx";
        tgl_mode   = 1'b0;
        stall_mode = 1'b0;
        mem[24'h300 / 4] = make_isp(24'h300, 1, 0, 1);
        kick(24'h300, 5, 0);
        repeat (10) @(posedge clk);
        chk("busy_before_abort", 96'(bus.busy), 96'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_parse("after_reset", 24'h000, 3, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
